// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - shared types and helpers for the PE chain sequencer
// Contents: FSM state enum, stage count, result-count and length-check helpers.
package pe_sched_pkg;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // Each stage divides the word count by ACC_LEN, so the last stage
    // produces len / ACC_LEN**4 results.
    function automatic logic [31:0] exp_results(input logic [31:0] len, input int acc_log2);
        return len >> (4 * acc_log2);
    endfunction

    // A job is only accepted if it fills whole groups in every stage.
    function automatic logic len_ok(input logic [31:0] len, input int acc_log2);
        logic [31:0] mask;
        mask = (32'd1 << (4 * acc_log2)) - 32'd1;
        return (len != 32'd0) && ((len & mask) == 32'd0);
    endfunction

endpackage

// File: rtl/pe_stage_seq.sv
// rtl/pe_stage_seq.sv - read/MAC/forward sequencing for one PE stage
// Ports: clk, rst (sync, active-high), clr (abort), run (job active),
//        empty (own FIFO), ds_full (downstream FIFO), rd_en, mac_en,
//        acc_clr, fwd_wr (accumulator result write to the next FIFO).
module pe_stage_seq #(
    parameter int ACC_LOG2 = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic empty,
    input  logic ds_full,
    output logic rd_en,
    output logic mac_en,
    output logic acc_clr,
    output logic fwd_wr
);

    localparam int ACC_LEN = 1 << ACC_LOG2;
    localparam int CW      = ACC_LOG2 + 1;

    logic [CW-1:0] grp_cnt;
    logic          mac_q;
    logic          pend;
    logic          closing;

    // The closing MAC is in flight this cycle, so the group already has all
    // its reads; holding off here produces the single bubble between groups.
    // pend is high in the forward cycle, where the next group may read again.
    assign closing = mac_q && (grp_cnt == CW'(ACC_LEN - 1));
    assign rd_en   = run && !empty && !ds_full && !closing;
    assign mac_en  = mac_q;
    assign acc_clr = pend;
    assign fwd_wr  = pend;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            grp_cnt <= '0;
            mac_q   <= 1'b0;
            pend    <= 1'b0;
        end else begin
            mac_q <= rd_en;
            pend  <= closing;
            if (mac_q) begin
                grp_cnt <= closing ? '0 : grp_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pe_chain_sched.sv
// rtl/pe_chain_sched.sv - job FSM and enable generation for the 4-stage PE chain
// Ports: start/len_words/abort from the tile controller; in_valid/in_ready
//        input handshake; fifo_full/fifo_empty flags; rd_en/wr_en/mac_en/
//        acc_clr per stage; result_valid, busy, done, err status.
module pe_chain_sched #(
    parameter int NUM_STAGES = 4,
    parameter int ACC_LOG2   = 1,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len_words,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STAGES-1:0] fifo_full,
    input  logic [NUM_STAGES-1:0] fifo_empty,
    output logic [NUM_STAGES-1:0] rd_en,
    output logic [NUM_STAGES-1:0] wr_en,
    output logic [NUM_STAGES-1:0] mac_en,
    output logic [NUM_STAGES-1:0] acc_clr,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import pe_sched_pkg::*;

    sched_state_t          state, state_nxt;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      in_cnt;
    logic [LEN_W-1:0]      res_cnt;
    logic [LEN_W-1:0]      exp_cnt;
    logic                  active;
    logic                  start_ok;
    logic [NUM_STAGES-1:0] ds_full;
    logic [NUM_STAGES-1:0] fwd;

    assign active   = (state == RUN) || (state == FLUSH);
    assign start_ok = len_ok(32'(len_words), ACC_LOG2);
    assign exp_cnt  = LEN_W'(exp_results(32'(len_q), ACC_LOG2));

    // The last stage has no downstream FIFO.
    assign ds_full  = {1'b0, fifo_full[NUM_STAGES-1:1]};

    assign in_ready     = (state == RUN) && !fifo_full[0] && (in_cnt < len_q);
    assign wr_en        = {fwd[NUM_STAGES-2:0], in_valid && in_ready};
    assign result_valid = fwd[NUM_STAGES-1];

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        pe_stage_seq #(.ACC_LOG2(ACC_LOG2)) u_seq (
            .clk     (clk),
            .rst     (rst),
            .clr     (abort),
            .run     (active),
            .empty   (fifo_empty[g]),
            .ds_full (ds_full[g]),
            .rd_en   (rd_en[g]),
            .mac_en  (mac_en[g]),
            .acc_clr (acc_clr[g]),
            .fwd_wr  (fwd[g])
        );
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_ok) state_nxt = RUN;
                    else          err       = 1'b1;
                end
            end
            RUN: begin
                if (in_cnt == len_q) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (res_cnt == exp_cnt) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            done      = 1'b0;
            err       = 1'b0;
        end
    end

    // busy drops in the completion cycle itself.
    assign busy = active && !done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            in_cnt  <= '0;
            res_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                in_cnt  <= '0;
                res_cnt <= '0;
            end else if (state == IDLE && start && start_ok) begin
                len_q   <= len_words;
                in_cnt  <= '0;
                res_cnt <= '0;
            end else begin
                if (wr_en[0])     in_cnt  <= in_cnt + LEN_W'(1);
                if (result_valid) res_cnt <= res_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_chain_sched.sv
// tb/tb_pe_chain_sched.sv - scoreboard bench for pe_chain_sched
module tb_pe_chain_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len_words;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fifo_full;
    logic [3:0]  fifo_empty;
    logic [3:0]  rd_en, wr_en, mac_en, acc_clr;
    logic        result_valid, busy, done, err;

    always #5 clk = ~clk;

    pe_chain_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len_words    (len_words),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .mac_en       (mac_en),
        .acc_clr      (acc_clr),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Depth-4 FIFO occupancy model; the PE reset is modelled by fifo_rst.
    int fc[4];
    bit force1;
    bit fifo_rst;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_full[i]  = (fc[i] >= 4) || (i == 1 && force1);
            fifo_empty[i] = (fc[i] == 0);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || fifo_rst) fc[i] <= 0;
            else                 fc[i] <= fc[i] + int'(wr_en[i]) - int'(rd_en[i]);
        end
    end

    // Scoreboard: one record per expected done/err event.
    typedef struct {
        bit is_err;
        int w0, w1, w2, w3, rv;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    bit prev_rd[4];
    bit pm[4];
    int mc[4];
    int cw[4];
    int crv;
    bit prev_rv;

    always @(negedge clk) begin
        if (!rst) begin
            chk("wr0_handshake", int'(wr_en[0]), int'(in_valid & in_ready));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("mac_follows_rd%0d", i), int'(mac_en[i]), int'(prev_rd[i]));
                chk($sformatf("acc_clr%0d", i), int'(acc_clr[i]), int'(pm[i]));
                if (rd_en[i])
                    chk($sformatf("underflow%0d", i), int'(fc[i] > 0), 1);
                if (wr_en[i] && !rd_en[i])
                    chk($sformatf("overflow%0d", i), int'(fc[i] < 4), 1);
                cw[i] += int'(wr_en[i]);
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("fwd_wr%0d", i + 1), int'(wr_en[i + 1]), int'(acc_clr[i]));
            chk("result_fwd", int'(result_valid), int'(acc_clr[3]));
            crv += int'(result_valid);

            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_err", int'(err), int'(e.is_err));
                    if (!e.is_err) begin
                        chk("cnt_wr0", cw[0], e.w0);
                        chk("cnt_wr1", cw[1], e.w1);
                        chk("cnt_wr2", cw[2], e.w2);
                        chk("cnt_wr3", cw[3], e.w3);
                        chk("cnt_result", crv, e.rv);
                    end
                end
                for (int i = 0; i < 4; i++) cw[i] = 0;
                crv = 0;
            end
            if (done) begin
                chk("busy_at_done", int'(busy), 0);
                chk("done_after_rv", int'(prev_rv), 1);
            end

            for (int i = 0; i < 4; i++) begin
                pm[i]      = mac_en[i] && (mc[i] == 1);
                mc[i]      = mac_en[i] ? (mc[i] + 1) % 2 : mc[i];
                prev_rd[i] = rd_en[i];
            end
            prev_rv = result_valid;

            if (abort) begin
                for (int i = 0; i < 4; i++) begin
                    pm[i] = 0; mc[i] = 0; prev_rd[i] = 0; cw[i] = 0;
                end
                crv = 0;
            end
        end
    end

    task automatic push_job;
        exp_t r;
        r.is_err = 0; r.w0 = 16; r.w1 = 8; r.w2 = 4; r.w3 = 2; r.rv = 1;
        sb.push_back(r);
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(posedge clk); #1;
        start = 1'b1; len_words = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
        in_valid = 1'b0;
    endtask

    task automatic count_words(input int target, output int n);
        n = 0;
        for (int k = 0; k < 400 && n < target; k++) begin
            @(negedge clk);
            if (wr_en[0]) n++;
        end
    endtask

    initial begin
        exp_t r;
        int   n;
        bit   found;

        rst = 1'b1; start = 1'b0; len_words = '0; abort = 1'b0;
        in_valid = 1'b0; force1 = 0; fifo_rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            int'({in_ready, rd_en, wr_en, mac_en, acc_clr, result_valid, busy, done, err}), 0);

        // Bad length: not a multiple of 16.
        r.is_err = 1; r.w0 = 0; r.w1 = 0; r.w2 = 0; r.w3 = 0; r.rv = 0;
        sb.push_back(r);
        pulse_start(16'd5);
        @(negedge clk);
        chk("err_no_busy", int'(busy), 0);
        chk("err_one_cycle", int'(err), 0);
        chk("err_consumed", sb.size(), 0);

        // Plain job.
        push_job();
        in_valid = 1'b1;
        pulse_start(16'd16);
        wait_idle("job1_complete");

        // Back-pressure on FIFO 1 mid-group.
        push_job();
        in_valid = 1'b1;
        pulse_start(16'd16);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rd_en[0]) begin
                found = 1;
                break;
            end
        end
        chk("stall_armed", int'(found), 1);
        @(posedge clk); #1 force1 = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rd0", int'(rd_en[0]), 0);
        end
        @(posedge clk); #1 force1 = 0;
        wait_idle("stall_complete");

        // Abort after seven accepted words.
        in_valid = 1'b1;
        pulse_start(16'd16);
        count_words(7, n);
        chk("abort_armed", n, 7);
        @(posedge clk); #1 abort = 1'b1; fifo_rst = 1;
        @(posedge clk); #1 abort = 1'b0; fifo_rst = 0;
        @(negedge clk);
        chk("abort_enables", int'({rd_en, wr_en, mac_en, acc_clr, result_valid}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);

        // Restart after abort.
        push_job();
        in_valid = 1'b1;
        pulse_start(16'd16);
        wait_idle("restart_complete");

        // start during FLUSH is ignored.
        push_job();
        in_valid = 1'b1;
        pulse_start(16'd16);
        count_words(16, n);
        chk("flush_words", n, 16);
        repeat (3) @(posedge clk);
        pulse_start(16'd16);
        wait_idle("flush_complete");
        repeat (40) @(negedge clk);
        chk("flush_no_extra_job", int'(busy), 0);
        chk("flush_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
